hazard_ctrl_unit: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC-V core; works alongside the operand forwarding logic.
- Detects load-use hazards and inserts stalls, flushes on taken branches, and freezes the front of the pipe while a multi-cycle mul/div op occupies EX.
- Issues write-enable, flush and bubble controls for the PC, IF/ID, ID/EX and EX/MEM registers. Keeps optional performance counters.

---
 rtl/hazard_ctrl_unit.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: load-use stall, branch flush, mul/div freeze with hang detect; controls are zero-latency.
// Latency: control outputs combinational from state+inputs; halt and perf counters registered (+1 cycle).
// Backpressure: freeze holds PC/IF/ID/ID/EX and bubbles EX/MEM; counters only with HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_ID,
  input  logic [4:0]       Rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       Rd_ID_EX,
  input  logic             MemRead_ID_EX,
  input  logic             branch_taken_EX,
  input  logic             md_start_EX,
  input  logic             md_done,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_bubble,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] md_wait_cycles
);

  typedef enum logic [1:0] {RUN, MD_BUSY, HALT} state_t;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  state_t     state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       halt_q;
  logic       lu, frz;
  logic       frz_act, br_act, lu_act;

  assign lu = MemRead_ID_EX && (Rd_ID_EX != 5'd0) &&
              ((use_rs1_ID && (Rd_ID_EX == Rs1_ID)) || (use_rs2_ID && (Rd_ID_EX == Rs2_ID)));

  assign frz = ((state == RUN) && md_start_EX && !md_done) ||
               ((state == MD_BUSY) && !md_done) ||
               (state == HALT);

  // Reset forces idle controls even if the state register still holds MD_BUSY/HALT.
  assign frz_act = !rst && frz;
  assign br_act  = !rst && !frz && branch_taken_EX;
  assign lu_act  = !rst && !frz && !branch_taken_EX && lu;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      RUN: begin
        if (md_start_EX && !md_done) begin
          state_nxt = MD_BUSY;
          wcnt_nxt  = 8'd1;
        end
      end
      MD_BUSY: begin
        if (md_done)                state_nxt = RUN;
        else if (wcnt == WAIT_LIM)  state_nxt = HALT;
        else                        wcnt_nxt  = wcnt + 8'd1;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      wcnt   <= 8'd0;
      halt_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      wcnt   <= wcnt_nxt;
      halt_q <= (state_nxt == HALT);
    end
  end

  assign halt = halt_q;

  always_comb begin
    PC_write      = 1'b1;
    IF_ID_write   = 1'b1;
    IF_ID_flush   = 1'b0;
    ID_EX_write   = 1'b1;
    ID_EX_bubble  = 1'b0;
    EX_MEM_bubble = 1'b0;
    if (frz_act) begin
      PC_write      = 1'b0;
      IF_ID_write   = 1'b0;
      ID_EX_write   = 1'b0;
      EX_MEM_bubble = 1'b1;
    end else if (br_act) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (lu_act) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_q, flush_q, mdw_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
      mdw_q   <= '0;
    end else begin
      if (lu_act  && (stall_q != CNT_MAX)) stall_q <= stall_q + CNT_ONE;
      if (br_act  && (flush_q != CNT_MAX)) flush_q <= flush_q + CNT_ONE;
      if (frz_act && (mdw_q   != CNT_MAX)) mdw_q   <= mdw_q   + CNT_ONE;
    end
  end

  assign stall_cycles   = stall_q;
  assign flush_events   = flush_q;
  assign md_wait_cycles = mdw_q;
`else
  assign stall_cycles   = '0;
  assign flush_events   = '0;
  assign md_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit (MAX_WAIT=4): scoreboard of expected controls, counter spot checks.
module tb_hazard_ctrl_unit;

  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble}
  localparam logic [5:0] IDLE = 6'b110100;
  localparam logic [5:0] FRZ  = 6'b000001;
  localparam logic [5:0] BR   = 6'b111110;
  localparam logic [5:0] LU   = 6'b000110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, use_rs1_ID, use_rs2_ID, MemRead_ID_EX, branch_taken_EX, md_start_EX, md_done;
  logic [4:0] Rs1_ID, Rs2_ID, Rd_ID_EX;
  logic PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble, halt;
  logic [CNT_W-1:0] stall_cycles, flush_events, md_wait_cycles;

  hazard_ctrl_unit #(.MAX_WAIT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .Rd_ID_EX(Rd_ID_EX), .MemRead_ID_EX(MemRead_ID_EX), .branch_taken_EX(branch_taken_EX),
    .md_start_EX(md_start_EX), .md_done(md_done),
    .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble), .EX_MEM_bubble(EX_MEM_bubble),
    .halt(halt), .stall_cycles(stall_cycles), .flush_events(flush_events),
    .md_wait_cycles(md_wait_cycles)
  );

  typedef struct {
    string      tag;
    logic [5:0] ctrl;
    logic       halt;
    logic       halt_chk;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  // Drive one cycle of stimulus just after the edge and queue what the outputs must be.
  task automatic drv(input string tag, input logic r, input logic mr, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                     input logic br, input logic ms, input logic md,
                     input logic [5:0] ec, input logic eh, input logic ehc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; MemRead_ID_EX = mr; Rd_ID_EX = rd; Rs1_ID = rs1; use_rs1_ID = u1;
    Rs2_ID = rs2; use_rs2_ID = u2; branch_taken_EX = br; md_start_EX = ms; md_done = md;
    e.tag = tag; e.ctrl = ec; e.halt = eh; e.halt_chk = ehc;
    sb.push_back(e);
  endtask

  task automatic idle(input string tag);
    drv(tag, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, IDLE, 0, 1);
  endtask

  task automatic do_reset(input string tag);
    drv(tag, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, IDLE, 0, 0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, 32'({PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble}),
            32'(e.ctrl));
      if (e.halt_chk) check({e.tag, "_halt"}, 32'(halt), 32'(e.halt));
    end
  end

  always @(negedge clk)
    if (!rst && branch_taken_EX && md_start_EX)
      $display("[TB] note: illegal branch_taken_EX with md_start_EX driven; freeze expected to win");

  initial begin
    rst = 1; MemRead_ID_EX = 0; Rd_ID_EX = 0; Rs1_ID = 0; Rs2_ID = 0; use_rs1_ID = 0;
    use_rs2_ID = 0; branch_taken_EX = 0; md_start_EX = 0; md_done = 0;

    drv("rst", 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, IDLE, 0, 1);
    idle("post_rst");
    @(negedge clk);
    check("rst_stall", stall_cycles, 0);
    check("rst_flush", flush_events, 0);
    check("rst_mdw", md_wait_cycles, 0);

    // Load-use on rs1, then rs2, then non-hazard variants.
    drv("lu_rs1", 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 0, LU, 0, 1);
    idle("lu_rs1_rel");
    @(negedge clk);
    check("stall_1", stall_cycles, cnt(1));
    drv("lu_rs2", 0, 1, 5'd7, 5'd3, 1, 5'd7, 1, 0, 0, 0, LU, 0, 1);
    idle("lu_rs2_rel");
    drv("rd0", 0, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, IDLE, 0, 1);
    drv("nouse", 0, 1, 5'd5, 5'd5, 0, 5'd6, 1, 0, 0, 0, IDLE, 0, 1);
    drv("noload", 0, 0, 5'd5, 5'd5, 1, 5'd5, 1, 0, 0, 0, IDLE, 0, 1);
    idle("nohaz_rel");
    @(negedge clk);
    check("stall_2", stall_cycles, cnt(2));

    // Branch suppresses a coincident load-use.
    do_reset("rst_br");
    drv("br_lu", 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, 0, BR, 0, 1);
    idle("br_rel");
    @(negedge clk);
    check("br_flush", flush_events, cnt(1));
    check("br_stall", stall_cycles, cnt(0));

    // Mul/div completes after 4 frozen cycles; done wins at wcnt==MAX_WAIT.
    do_reset("rst_md");
    drv("md0", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 1);
    drv("md1_lu", 0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 1, 0, FRZ, 0, 1);
    drv("md2_br", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, FRZ, 0, 1);
    drv("md3", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 1);
    drv("md4_rel", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, IDLE, 0, 1);
    drv("md_run_lu", 0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 0, 0, 0, LU, 0, 1);
    idle("md_after");
    @(negedge clk);
    check("md_wait_4", md_wait_cycles, cnt(4));
    check("md_stall", stall_cycles, cnt(1));
    check("md_flush", flush_events, cnt(0));

    // Hang: no md_done, HALT entered after MAX_WAIT busy cycles and is sticky.
    do_reset("rst_hang");
    drv("hang0", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 1);
    for (int i = 1; i <= 4; i++)
      drv($sformatf("hang%0d", i), 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 1);
    drv("halt5", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, FRZ, 1, 1);
    drv("halt6_done", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, FRZ, 1, 1);
    drv("halt7_br", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 0, 0, FRZ, 1, 1);
    drv("halt8_lu", 0, 1, 5'd4, 5'd4, 1, 5'd0, 0, 0, 0, 0, FRZ, 1, 1);
    do_reset("rst_halt");
    @(negedge clk);
    check("hang_mdw_9", md_wait_cycles, cnt(9));
    idle("halt_clr");
    @(negedge clk);
    check("halt_clr_mdw", md_wait_cycles, 0);
    check("halt_clr_flush", flush_events, 0);

    // Reset while busy, then single-cycle mul/div does not freeze.
    drv("busy0", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 1);
    drv("busy1", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0, 1);
    drv("rst_busy", 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, IDLE, 0, 1);
    idle("post_rst_busy");
    drv("md_single", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, IDLE, 0, 1);
    drv("md_single_lu", 0, 1, 5'd2, 5'd0, 0, 5'd2, 1, 0, 1, 1, LU, 0, 1);
    idle("single_after");
    @(negedge clk);
    check("single_mdw", md_wait_cycles, cnt(0));
    check("single_stall", stall_cycles, cnt(1));

    // Illegal branch together with md start: freeze wins, branch not counted.
    drv("br_md", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, FRZ, 0, 1);
    drv("br_md_rel", 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, IDLE, 0, 1);
    idle("br_md_after");
    @(negedge clk);
    check("br_md_flush", flush_events, cnt(0));
    check("br_md_mdw", md_wait_cycles, cnt(1));

    #1;
    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
